// File: rtl/shift_sequencer.sv
// Command sequencer for the 4-bit barrel shifter: splits a shift/rotate of up to
// 2^AMT_W-1 positions into passes of at most 3 bits and returns the final word.
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_select,
    input  logic             cmd_direction,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [3:0]       cmd_data,
    output logic             bs_select,
    output logic             bs_direction,
    output logic [1:0]       bs_shift_value,
    output logic [3:0]       bs_din,
    input  logic [3:0]       bs_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         work;
    logic [AMT_W-1:0]   remaining;
    logic               sel_q;
    logic               dir_q;

    // Two guard bits keep the step arithmetic correct for any AMT_W, including 1.
    logic [AMT_W+1:0]   rem_x;
    logic [AMT_W+1:0]   rem_left;
    logic [1:0]         step;

    always_comb begin
        rem_x    = {2'b00, remaining};
        step     = (rem_x >= (AMT_W+2)'(3)) ? 2'd3 : rem_x[1:0];
        rem_left = rem_x - (AMT_W+2)'(step);
    end

    // NOTE: every output of the combinational block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (cmd_amount != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (rem_left == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            sel_q     <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        work      <= cmd_data;
                        remaining <= cmd_amount;
                        sel_q     <= cmd_select;
                        dir_q     <= cmd_direction;
                    end
                end
                RUN: begin
                    work      <= bs_dout;
                    remaining <= rem_left[AMT_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // All outputs come from registered state; bs_dout only feeds back into work.
    assign cmd_ready      = (state == IDLE);
    assign res_valid      = (state == DONE);
    assign res_data       = work;
    assign bs_select      = sel_q;
    assign bs_direction   = dir_q;
    assign bs_din         = work;
    assign bs_shift_value = (state == RUN) ? step : 2'd0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: models the barrel shifter and checks
// pass sequences and results against whole-amount shift/rotate arithmetic.
module tb_shift_sequencer;

    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_select;
    logic             cmd_direction;
    logic [AMT_W-1:0] cmd_amount;
    logic [3:0]       cmd_data;
    logic             bs_select;
    logic             bs_direction;
    logic [1:0]       bs_shift_value;
    logic [3:0]       bs_din;
    logic [3:0]       bs_dout;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_select     (cmd_select),
        .cmd_direction  (cmd_direction),
        .cmd_amount     (cmd_amount),
        .cmd_data       (cmd_data),
        .bs_select      (bs_select),
        .bs_direction   (bs_direction),
        .bs_shift_value (bs_shift_value),
        .bs_din         (bs_din),
        .bs_dout        (bs_dout),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data)
    );

    // Move a 4-bit word by amt positions: rotate wraps modulo 4, logical shift
    // fills with zeros and empties the word for amounts of 4 or more.
    function automatic logic [3:0] move(input logic sel, input logic dir,
                                        input int amt, input logic [3:0] d);
        int t;
        int r;
        t = int'({d, d});
        if (sel) begin
            r = amt % 4;
            if (dir) return 4'((t << r) >> 4);
            else     return 4'(t >> r);
        end
        if (amt >= 4) return 4'd0;
        if (dir) return 4'(int'(d) << amt);
        return 4'(int'(d) >> amt);
    endfunction

    // Barrel shifter stand-in, combinational from the sequencer's bs_* outputs.
    always_comb bs_dout = move(bs_select, bs_direction, int'(bs_shift_value), bs_din);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_select    = 1'($urandom);
        cmd_direction = 1'($urandom);
        cmd_amount    = AMT_W'($urandom_range(1, 15));
        cmd_data      = 4'($urandom);
    endtask

    // Issue one command from IDLE, follow every pass, hold the result for
    // 'hold' cycles with a competing command pending, then hand it off.
    task automatic run_cmd(input logic sel, input logic dir, input int amt,
                           input logic [3:0] data, input int hold);
        int         rem;
        int         step;
        logic [3:0] w;
        logic [3:0] expv;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_select    = sel;
        cmd_direction = dir;
        cmd_amount    = AMT_W'(amt);
        cmd_data      = data;
        tick();
        cmd_valid = 1'b0;
        junk_cmd();
        rem = amt;
        w   = data;
        while (rem > 0) begin
            step = (rem > 3) ? 3 : rem;
            check("pass_shift_value", 32'(bs_shift_value), 32'(step));
            check("pass_din",         32'(bs_din),         32'(w));
            check("pass_select",      32'(bs_select),      32'(sel));
            check("pass_direction",   32'(bs_direction),   32'(dir));
            check("pass_res_valid",   32'(res_valid),      32'd0);
            check("pass_cmd_ready",   32'(cmd_ready),      32'd0);
            w   = move(sel, dir, step, w);
            rem = rem - step;
            tick();
        end
        expv = move(sel, dir, amt, data);
        check("done_res_valid",   32'(res_valid),      32'd1);
        check("done_res_data",    32'(res_data),       32'(expv));
        check("done_shift_value", 32'(bs_shift_value), 32'd0);
        check("done_cmd_ready",   32'(cmd_ready),      32'd0);
        cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data",  32'(res_data),  32'(expv));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        check("handoff_cmd_ready",   32'(cmd_ready),      32'd1);
        check("handoff_res_valid",   32'(res_valid),      32'd0);
        check("handoff_shift_value", 32'(bs_shift_value), 32'd0);
        check("handoff_work_held",   32'(res_data),       32'(expv));
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        junk_cmd();

        // Reset held for two cycles.
        tick();
        tick();
        reset = 1'b0;
        check("rst_cmd_ready",   32'(cmd_ready),      32'd1);
        check("rst_res_valid",   32'(res_valid),      32'd0);
        check("rst_res_data",    32'(res_data),       32'd0);
        check("rst_shift_value", 32'(bs_shift_value), 32'd0);
        check("rst_din",         32'(bs_din),         32'd0);
        check("rst_select",      32'(bs_select),      32'd0);
        check("rst_direction",   32'(bs_direction),   32'd0);

        // Directed cases.
        run_cmd(1'b1, 1'b1, 5,  4'b1001, 0);
        check("rotl5_result_literal", 32'(res_data), 32'b0011);
        run_cmd(1'b0, 1'b0, 7,  4'b1111, 0);
        run_cmd(1'b0, 1'b0, 2,  4'b1100, 0);
        check("shr2_result_literal", 32'(res_data), 32'b0011);
        run_cmd(1'b0, 1'b1, 0,  4'b1010, 1);
        check("amt0_result_literal", 32'(res_data), 32'b1010);
        run_cmd(1'b1, 1'b1, 15, 4'b0001, 5);
        check("rotl15_result_literal", 32'(res_data), 32'b1000);

        // Reset during the second RUN cycle of rotate 15.
        cmd_valid     = 1'b1;
        cmd_select    = 1'b1;
        cmd_direction = 1'b1;
        cmd_amount    = AMT_W'(15);
        cmd_data      = 4'b0110;
        tick();
        cmd_valid = 1'b0;
        check("abort_pass1", 32'(bs_shift_value), 32'd3);
        tick();
        check("abort_pass2", 32'(bs_shift_value), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_cmd_ready",   32'(cmd_ready),      32'd1);
        check("abort_res_valid",   32'(res_valid),      32'd0);
        check("abort_work",        32'(res_data),       32'd0);
        check("abort_din",         32'(bs_din),         32'd0);
        check("abort_shift_value", 32'(bs_shift_value), 32'd0);
        check("abort_select",      32'(bs_select),      32'd0);
        check("abort_direction",   32'(bs_direction),   32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_result", 32'(res_valid), 32'd0);
        end

        // Randomized commands across the whole amount range.
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                    4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
